// File: rtl/am2901_pkg.sv
// Shared decode enums for the Am2901-style slice and its multiply sequencer FSM.
package am2901_pkg;

  typedef enum logic [2:0] {
    SRC_AQ, SRC_AB, SRC_ZQ, SRC_ZB, SRC_ZA, SRC_DA, SRC_DQ, SRC_DZ
  } src_e;

  typedef enum logic [2:0] {
    FN_ADD, FN_SUBR, FN_SUBS, FN_OR, FN_AND, FN_NOTRS, FN_EXOR, FN_EXNOR
  } func_e;

  typedef enum logic [2:0] {
    DST_QREG, DST_NOP, DST_RAMA, DST_RAMF, DST_RAMQD, DST_RAMD, DST_RAMQU, DST_RAMU
  } dest_e;

  typedef enum logic [1:0] {
    IDLE, RUN, DONE
  } state_e;

endpackage

// File: rtl/am2901_slice_seq_if.sv
// Microinstruction, data and shift-pin bundle of the slice; master drives, slave is the slice.
interface am2901_slice_seq_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic [8:0]       i;
  logic [AW-1:0]    a;
  logic [AW-1:0]    b;
  logic [WIDTH-1:0] d;
  logic             cin;
  logic             oe;
  logic [WIDTH-1:0] y;
  logic             y_en;
  logic             cout;
  logic             ovr;
  logic             z;
  logic             f3;
  logic             g_lo;
  logic             p_lo;
  logic [3:0]       flags_q;
  logic             ram0_i, ram3_i, q0_i, q3_i;
  logic             ram0_o, ram3_o, q0_o, q3_o;
  logic             ram0_oe, ram3_oe, q0_oe, q3_oe;
  logic             start;
  logic             busy;
  logic             done;

  modport master (
    output i, a, b, d, cin, oe, ram0_i, ram3_i, q0_i, q3_i, start,
    input  y, y_en, cout, ovr, z, f3, g_lo, p_lo, flags_q,
    input  ram0_o, ram3_o, q0_o, q3_o, ram0_oe, ram3_oe, q0_oe, q3_oe, busy, done
  );

  modport slave (
    input  i, a, b, d, cin, oe, ram0_i, ram3_i, q0_i, q3_i, start,
    output y, y_en, cout, ovr, z, f3, g_lo, p_lo, flags_q,
    output ram0_o, ram3_o, q0_o, q3_o, ram0_oe, ram3_oe, q0_oe, q3_oe, busy, done
  );
endinterface

// File: rtl/am2901_alu_core.sv
// Combinational R/S ALU: eight Am2901 functions, carry/overflow and active-low lookahead G/P.
// Zero latency, no flow control.
module am2901_alu_core
  import am2901_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  func_e            func,
  input  logic             cin,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovr,
  output logic             g_lo,
  output logic             p_lo
);
  logic [WIDTH-1:0] r_eff, s_eff, gen, prop;
  logic [WIDTH:0]   sum;
  logic             arith, g_acc;

  always_comb begin
    r_eff = r;
    s_eff = s;
    arith = 1'b1;
    case (func)
      FN_SUBR: r_eff = ~r;
      FN_SUBS: s_eff = ~s;
      FN_ADD:  arith = 1'b1;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, r_eff} + {1'b0, s_eff} + {{WIDTH{1'b0}}, cin};

    case (func)
      FN_OR:    f = r | s;
      FN_AND:   f = r & s;
      FN_NOTRS: f = ~r & s;
      FN_EXOR:  f = r ^ s;
      FN_EXNOR: f = ~(r ^ s);
      default:  f = sum[WIDTH-1:0];
    endcase

    cout = arith & sum[WIDTH];
    // carry into the MSB recovered from the MSB sum bit and its operands
    ovr  = arith & (sum[WIDTH] ^ (sum[WIDTH-1] ^ r_eff[WIDTH-1] ^ s_eff[WIDTH-1]));

    gen   = r_eff & s_eff;
    prop  = r_eff | s_eff;
    g_acc = 1'b0;
    for (int k = 0; k < WIDTH; k++) g_acc = gen[k] | (prop[k] & g_acc);
    g_lo = ~g_acc;
    p_lo = ~(&prop);
  end
endmodule

// File: rtl/am2901_slice_seq.sv
// WIDTH-bit Am2901-style slice with register file, Q register, registered flags and a shift-add
// multiply sequencer; i executes in one cycle, multiply takes WIDTH cycles with i ignored while busy.
module am2901_slice_seq
  import am2901_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = 16
) (
  input logic cp,
  input logic rst,
  am2901_slice_seq_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state;
  logic [WIDTH-1:0] ram [NREGS];
  logic [WIDTH-1:0] q_reg;
  logic [AW-1:0]    aa, bb;
  logic [CW-1:0]    cnt;
  logic [3:0]       flags_r;
  logic             busy_r, done_r;

  src_e  src;
  func_e func, alu_func;
  dest_e dest;
  logic  run, alu_cin, alu_cout, alu_ovr, zero, lo_en, hi_en;
  logic  ram_we, q_we;
  logic [WIDTH-1:0] a_dat, b_dat, dec_r, dec_s, alu_r, alu_s, f, ram_wd, q_wd;

  assign src   = src_e'(bus.i[2:0]);
  assign func  = func_e'(bus.i[5:3]);
  assign dest  = dest_e'(bus.i[8:6]);
  assign run   = (state == RUN);
  assign a_dat = ram[bus.a];
  assign b_dat = ram[bus.b];

  always_comb begin
    dec_r = '0;
    dec_s = '0;
    case (src)
      SRC_AQ:  begin dec_r = a_dat;  dec_s = q_reg; end
      SRC_AB:  begin dec_r = a_dat;  dec_s = b_dat; end
      SRC_ZQ:  dec_s = q_reg;
      SRC_ZB:  dec_s = b_dat;
      SRC_ZA:  dec_s = a_dat;
      SRC_DA:  begin dec_r = bus.d;  dec_s = a_dat; end
      SRC_DQ:  begin dec_r = bus.d;  dec_s = q_reg; end
      default: dec_r = bus.d;
    endcase
  end

  // The sequencer borrows the single ALU: acc + (Q[0] ? multiplicand : 0)
  assign alu_r    = run ? (q_reg[0] ? ram[aa] : '0) : dec_r;
  assign alu_s    = run ? ram[bb] : dec_s;
  assign alu_func = run ? FN_ADD : func;
  assign alu_cin  = run ? 1'b0 : bus.cin;

  am2901_alu_core #(.WIDTH(WIDTH)) u_alu (
    .r    (alu_r),
    .s    (alu_s),
    .func (alu_func),
    .cin  (alu_cin),
    .f    (f),
    .cout (alu_cout),
    .ovr  (alu_ovr),
    .g_lo (bus.g_lo),
    .p_lo (bus.p_lo)
  );

  assign zero  = (f == '0);
  assign lo_en = !run && (dest == DST_RAMQD || dest == DST_RAMD);
  assign hi_en = !run && (dest == DST_RAMQU || dest == DST_RAMU);

  assign bus.y       = !bus.oe ? '0 : ((!run && dest == DST_RAMA) ? a_dat : f);
  assign bus.y_en    = bus.oe;
  assign bus.cout    = alu_cout;
  assign bus.ovr     = alu_ovr;
  assign bus.z       = zero;
  assign bus.f3      = f[WIDTH-1];
  assign bus.flags_q = flags_r;
  assign bus.ram0_o  = f[0];
  assign bus.q0_o    = q_reg[0];
  assign bus.ram3_o  = f[WIDTH-1];
  assign bus.q3_o    = q_reg[WIDTH-1];
  assign bus.ram0_oe = lo_en;
  assign bus.q0_oe   = lo_en;
  assign bus.ram3_oe = hi_en;
  assign bus.q3_oe   = hi_en;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  always_comb begin
    ram_we = 1'b0;
    ram_wd = f;
    q_we   = 1'b0;
    q_wd   = f;
    case (dest)
      DST_QREG:           q_we = 1'b1;
      DST_RAMA, DST_RAMF: ram_we = 1'b1;
      DST_RAMQD, DST_RAMD: begin
        ram_we = 1'b1;
        ram_wd = {bus.ram3_i, f[WIDTH-1:1]};
        q_we   = (dest == DST_RAMQD);
        q_wd   = {bus.q3_i, q_reg[WIDTH-1:1]};
      end
      DST_RAMQU, DST_RAMU: begin
        ram_we = 1'b1;
        ram_wd = {f[WIDTH-2:0], bus.ram0_i};
        q_we   = (dest == DST_RAMQU);
        q_wd   = {q_reg[WIDTH-2:0], bus.q0_i};
      end
      default: ram_we = 1'b0;
    endcase
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREGS; n++) ram[n] <= '0;
      q_reg   <= '0;
      flags_r <= '0;
      aa      <= '0;
      bb      <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      state   <= IDLE;
    end else begin
      if (!run) begin
        if (ram_we) ram[bus.b] <= ram_wd;
        if (q_we)   q_reg      <= q_wd;
        flags_r <= {alu_cout, alu_ovr, zero, f[WIDTH-1]};
      end
      case (state)
        IDLE: if (bus.start) begin
          aa     <= bus.a;
          bb     <= bus.b;
          cnt    <= CW'(WIDTH);
          busy_r <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          ram[bb] <= {alu_cout, f[WIDTH-1:1]};
          q_reg   <= {f[0], q_reg[WIDTH-1:1]};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
